// File: rtl/gio_int_ctrl_pkg.sv
// Shared definitions for the GIO interrupt aggregator: register map defaults, FSM encodings, helpers.
// The optional source-ID capture is enabled by defining GIO_INT_PRIO_EN.
package gio_int_ctrl_pkg;

  localparam int         N_SRC_DEF     = 4;
  localparam logic [7:0] ADDR_PEND_DEF = 8'h20;
  localparam logic [7:0] ADDR_MASK_DEF = 8'h21;
  localparam logic [7:0] ADDR_CLR_DEF  = 8'h22;
  localparam logic [7:0] ADDR_ID_DEF   = 8'h23;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_INSVC = 2'd2;

  typedef struct packed {
    logic mask;
    logic clr;
  } wr_dec_t;

  function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] target,
                                    input logic strobe);
    return strobe & (addr == target);
  endfunction

  // ID register format: bit 7 flags a valid capture, low bits carry the source index.
  function automatic logic [7:0] id_code(input logic [2:0] idx);
    return {1'b1, 4'b0000, idx};
  endfunction

endpackage

// File: rtl/gio_int_ctrl_if.sv
// CPU port-mapped I/O plus IOC interrupt handshake bundle for gio_int_ctrl.
interface gio_int_ctrl_if #(
  parameter int N_SRC = 4
);
  logic [7:0]       address;
  logic [7:0]       data_in;
  logic [7:0]       data_out;
  logic             wen;
  logic             ren;
  logic [N_SRC-1:0] int_src;
  logic [N_SRC-1:0] int_src_ack;
  logic             interrupt;
  logic             interrupt_ack;

  modport master (
    output address, data_in, wen, ren, int_src, interrupt_ack,
    input  data_out, int_src_ack, interrupt
  );

  modport slave (
    input  address, data_in, wen, ren, int_src, interrupt_ack,
    output data_out, int_src_ack, interrupt
  );
endinterface

// File: rtl/gio_int_prio_enc.sv
// Lowest-index-first priority encoder (8 requests -> 3-bit index + valid).
// Only compiled into the design when GIO_INT_PRIO_EN is defined.
`ifdef GIO_INT_PRIO_EN
module gio_int_prio_enc (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = 3'd0;
    valid = |req;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule
`endif

// File: rtl/gio_int_ctrl.sv
// Interrupt aggregator: edge-latched pending flags, mask, single CPU interrupt line, per-source acks.
// Define GIO_INT_PRIO_EN to add the captured source-ID register at ADDR_ID.
module gio_int_ctrl
  import gio_int_ctrl_pkg::*;
#(
  parameter int         N_SRC     = N_SRC_DEF,
  parameter logic [7:0] ADDR_PEND = ADDR_PEND_DEF,
  parameter logic [7:0] ADDR_MASK = ADDR_MASK_DEF,
  parameter logic [7:0] ADDR_CLR  = ADDR_CLR_DEF,
  parameter logic [7:0] ADDR_ID   = ADDR_ID_DEF
) (
  input logic          clk,
  input logic          rst,
  gio_int_ctrl_if.slave bus
);

  logic [N_SRC-1:0] src_q_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] ack_r;
  logic [1:0]       state_r;
  logic             irq_r;
  logic [7:0]       rdata_r;

  wr_dec_t          wr_s;
  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] clr_bits_s;
  logic [N_SRC-1:0] pend_nxt_s;
  logic [N_SRC-1:0] ack_nxt_s;
  logic             enabled_s;
  logic [1:0]       state_nxt_s;
  logic [7:0]       pend8_s;
  logic [7:0]       mask8_s;
  logic [7:0]       rd_data_s;
  logic             unused_s;

  assign unused_s = &{1'b0, bus.data_in};

`ifdef GIO_INT_PRIO_EN
  logic [7:0] id_r;
  logic [7:0] enc_in_s;
  logic [2:0] enc_idx_s;
  logic       enc_valid_s;
  logic       id_cap_s;
`endif

  // Write decode, edge detection and pending/ack next-state; a new edge beats a same-cycle clear.
  always_comb begin
    wr_s.mask  = addr_hit(bus.address, ADDR_MASK, bus.wen);
    wr_s.clr   = addr_hit(bus.address, ADDR_CLR, bus.wen);
    edge_s     = bus.int_src & ~src_q_r;
    if (wr_s.clr) begin
      clr_bits_s = bus.data_in[N_SRC-1:0];
    end else begin
      clr_bits_s = {N_SRC{1'b0}};
    end
    pend_nxt_s = (pending_r & ~clr_bits_s) | edge_s;
    ack_nxt_s  = clr_bits_s & pending_r & ~edge_s;
    enabled_s  = |(pending_r & mask_r);
  end

  // Read data mux; anything not addressed returns zero so the CPU input bus can be OR-combined.
  always_comb begin
    pend8_s                = 8'h00;
    pend8_s[N_SRC-1:0]     = pending_r;
    mask8_s                = 8'h00;
    mask8_s[N_SRC-1:0]     = mask_r;
    rd_data_s              = 8'h00;
    if (bus.ren) begin
      if (bus.address == ADDR_PEND) begin
        rd_data_s = pend8_s;
      end else if (bus.address == ADDR_MASK) begin
        rd_data_s = mask8_s;
`ifdef GIO_INT_PRIO_EN
      end else if (bus.address == ADDR_ID) begin
        rd_data_s = id_r;
`endif
      end else begin
        rd_data_s = 8'h00;
      end
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Request FSM: an ack takes priority over a simultaneous mask/clear withdrawing the request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enabled_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.interrupt_ack) begin
          state_nxt_s = ST_INSVC;
        end else if (!enabled_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_INSVC: begin
        if (wr_s.clr) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INSVC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Source sampling, pending flags, mask register and ack pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q_r   <= {N_SRC{1'b0}};
      pending_r <= {N_SRC{1'b0}};
      mask_r    <= {N_SRC{1'b0}};
      ack_r     <= {N_SRC{1'b0}};
    end else begin
      src_q_r   <= bus.int_src;
      pending_r <= pend_nxt_s;
      ack_r     <= ack_nxt_s;
      if (wr_s.mask) begin
        mask_r <= bus.data_in[N_SRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // FSM state, registered interrupt line (tracks the REQ state) and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      irq_r   <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      irq_r   <= (state_nxt_s == ST_REQ);
      rdata_r <= rd_data_s;
    end
  end

`ifdef GIO_INT_PRIO_EN
  // Encoder sees only enabled pending sources.
  always_comb begin
    enc_in_s            = 8'h00;
    enc_in_s[N_SRC-1:0] = pending_r & mask_r;
    id_cap_s            = (state_r == ST_REQ) & bus.interrupt_ack;
  end

  gio_int_prio_enc u_prio_enc (
    .req   (enc_in_s),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  // Capture the winning source when the CPU takes the interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_r <= 8'h00;
    end else if (id_cap_s & enc_valid_s) begin
      id_r <= id_code(enc_idx_s);
    end else begin
      id_r <= id_r;
    end
  end
`endif

  assign bus.data_out    = rdata_r;
  assign bus.int_src_ack = ack_r;
  assign bus.interrupt   = irq_r;

endmodule

// File: tb/tb_gio_int_ctrl.sv
// Directed self-checking bench for gio_int_ctrl: register-access vector table plus interrupt sequences.
module tb_gio_int_ctrl;
  import gio_int_ctrl_pkg::*;

  localparam logic [7:0] A_PEND  = 8'h20;
  localparam logic [7:0] A_MASK  = 8'h21;
  localparam logic [7:0] A_CLR   = 8'h22;
  localparam logic [7:0] A_ID    = 8'h23;
`ifdef GIO_INT_PRIO_EN
  localparam logic [7:0] EXP_ID1 = 8'h82;
  localparam logic [7:0] EXP_ID2 = 8'h83;
`else
  localparam logic [7:0] EXP_ID1 = 8'h00;
  localparam logic [7:0] EXP_ID2 = 8'h00;
`endif

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  vec_t vecs[11];
  logic [7:0] rd;
  logic [3:0] ak;

  gio_int_ctrl_if #(.N_SRC(4)) bus ();

  gio_int_ctrl #(.N_SRC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one strobe cycle and samples outputs at the following negedge.
  task automatic cpu_op(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output logic [3:0] ack);
    bus.address = addr;
    bus.data_in = wdata;
    bus.wen     = wr;
    bus.ren     = ~wr;
    @(negedge clk);
    rdata       = bus.data_out;
    ack         = bus.int_src_ack;
    bus.wen     = 1'b0;
    bus.ren     = 1'b0;
    bus.address = 8'h00;
    bus.data_in = 8'h00;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] r;
    logic [3:0] a;
    cpu_op(1'b0, addr, 8'h00, r, a);
    check(nm, r, exp);
  endtask

  task automatic wr_ack_chk(input string nm, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [3:0] exp_ack);
    logic [7:0] r;
    logic [3:0] a;
    cpu_op(1'b1, addr, wdata, r, a);
    check(nm, {4'h0, a}, {4'h0, exp_ack});
  endtask

  task automatic ack_pulse();
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.address = 8'h00;
    bus.data_in = 8'h00;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    bus.int_src = 4'b0000;
    bus.interrupt_ack = 1'b0;

    vecs[0]  = '{1'b0, A_PEND, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, A_MASK, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, A_ID,   8'h00, 8'h00};
    vecs[3]  = '{1'b1, A_MASK, 8'hA5, 8'h00};
    vecs[4]  = '{1'b0, A_MASK, 8'h00, 8'h05};
    vecs[5]  = '{1'b0, 8'h10,  8'h00, 8'h00};
    vecs[6]  = '{1'b1, A_MASK, 8'hFF, 8'h00};
    vecs[7]  = '{1'b0, A_MASK, 8'h00, 8'h0F};
    vecs[8]  = '{1'b0, 8'h24,  8'h00, 8'h00};
    vecs[9]  = '{1'b1, A_MASK, 8'h00, 8'h00};
    vecs[10] = '{1'b0, A_MASK, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_irq", {7'h00, bus.interrupt}, 8'h00);
    check("rst_ack", {4'h0, bus.int_src_ack}, 8'h00);
    check("rst_dout", bus.data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, ak);
      check($sformatf("vec%0d_dout", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {7'h00, bus.interrupt}, 8'h00);
    end

    // Reset while a request is outstanding.
    cpu_op(1'b1, A_MASK, 8'h01, rd, ak);
    bus.int_src = 4'b0001;
    repeat (3) @(negedge clk);
    check("t1_irq_req", {7'h00, bus.interrupt}, 8'h01);
    rst = 1'b1;
    bus.int_src = 4'b0000;
    #1;
    check("t1_irq_rst", {7'h00, bus.interrupt}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check("t1_ack_rst", {4'h0, bus.int_src_ack}, 8'h00);
    rd_chk("t1_pend", A_PEND, 8'h00);
    rd_chk("t1_mask", A_MASK, 8'h00);

    // Single source: 2-cycle latency, ack, clear with one-cycle ack pulse.
    cpu_op(1'b1, A_MASK, 8'h01, rd, ak);
    bus.int_src = 4'b0001;
    @(negedge clk);
    check("t2_lat1", {7'h00, bus.interrupt}, 8'h00);
    @(negedge clk);
    check("t2_lat2", {7'h00, bus.interrupt}, 8'h01);
    ack_pulse();
    check("t2_irq_acked", {7'h00, bus.interrupt}, 8'h00);
    wr_ack_chk("t2_ack_pulse", A_CLR, 8'h01, 4'b0001);
    bus.int_src = 4'b0000;
    @(negedge clk);
    check("t2_ack_end", {4'h0, bus.int_src_ack}, 8'h00);
    rd_chk("t2_pend", A_PEND, 8'h00);
    check("t2_irq_idle", {7'h00, bus.interrupt}, 8'h00);

    // Masked pending, then unmask one source.
    cpu_op(1'b1, A_MASK, 8'h00, rd, ak);
    bus.int_src = 4'b0110;
    repeat (2) @(negedge clk);
    rd_chk("t3_pend", A_PEND, 8'h06);
    check("t3_irq_masked", {7'h00, bus.interrupt}, 8'h00);
    cpu_op(1'b1, A_MASK, 8'h04, rd, ak);
    check("t3_irq_unmask0", {7'h00, bus.interrupt}, 8'h00);
    @(negedge clk);
    check("t3_irq_unmask1", {7'h00, bus.interrupt}, 8'h01);
    rd_chk("t3_pend_kept", A_PEND, 8'h06);
    ack_pulse();
    wr_ack_chk("t3_ack", A_CLR, 8'h06, 4'b0110);
    bus.int_src = 4'b0000;
    @(negedge clk);
    check("t3_irq_done", {7'h00, bus.interrupt}, 8'h00);

    // New edge on src1 in the same cycle as its clear: set wins, no ack, re-request.
    cpu_op(1'b1, A_MASK, 8'h02, rd, ak);
    bus.int_src = 4'b0010;
    repeat (3) @(negedge clk);
    check("t4_irq", {7'h00, bus.interrupt}, 8'h01);
    ack_pulse();
    bus.int_src = 4'b0000;
    @(negedge clk);
    bus.int_src = 4'b0010;
    wr_ack_chk("t4_no_ack", A_CLR, 8'h02, 4'b0000);
    check("t4_irq_drop", {7'h00, bus.interrupt}, 8'h00);
    @(negedge clk);
    check("t4_irq_rearm", {7'h00, bus.interrupt}, 8'h01);
    rd_chk("t4_pend", A_PEND, 8'h02);
    ack_pulse();
    wr_ack_chk("t4_ack", A_CLR, 8'h02, 4'b0010);
    bus.int_src = 4'b0000;
    @(negedge clk);

    // Source-ID capture (reads zero when the ID feature is not built).
    cpu_op(1'b1, A_MASK, 8'h0F, rd, ak);
    bus.int_src = 4'b1100;
    repeat (3) @(negedge clk);
    check("t5_irq", {7'h00, bus.interrupt}, 8'h01);
    ack_pulse();
    rd_chk("t5_id1", A_ID, EXP_ID1);
    wr_ack_chk("t5_ack2", A_CLR, 8'h04, 4'b0100);
    bus.int_src = 4'b1000;
    check("t5_irq_drop", {7'h00, bus.interrupt}, 8'h00);
    @(negedge clk);
    check("t5_irq_rearm", {7'h00, bus.interrupt}, 8'h01);
    ack_pulse();
    rd_chk("t5_id2", A_ID, EXP_ID2);
    wr_ack_chk("t5_ack3", A_CLR, 8'h08, 4'b1000);
    bus.int_src = 4'b0000;
    @(negedge clk);
    rd_chk("t5_pend", A_PEND, 8'h00);

    // Unmapped read, and a held source level must not set pending again.
    rd_chk("t6_unmapped", 8'h10, 8'h00);
    cpu_op(1'b1, A_MASK, 8'h00, rd, ak);
    bus.int_src = 4'b0001;
    repeat (2) @(negedge clk);
    wr_ack_chk("t6_ack", A_CLR, 8'h01, 4'b0001);
    repeat (4) @(negedge clk);
    rd_chk("t6_pend_held", A_PEND, 8'h00);
    check("t6_irq", {7'h00, bus.interrupt}, 8'h00);
    bus.int_src = 4'b0000;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
